// File: rtl/csrarb_pkg.sv
// Shared definitions for the two-requester CSR arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package csrarb_pkg;

  localparam int ADR_W = 14;
  localparam int DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/csrarb_rr.sv
// Grant selection between two CSR requesters.
// Latency: combinational grant; the tie pointer updates on the clock edge that takes a grant.
// Backpressure: none; the grant is only consumed while gnt_en is high.
//
// Ports: req[1:0] raw requests, gnt_vld any request pending, gnt_idx chosen requester.
// With CSRARB_ROUNDROBIN_EN defined: sys_clk/sys_rst and gnt_en (arbiter idle) are present
// and ties alternate. Without it: requester 0 always wins ties and no pointer exists.
module csrarb_rr (
`ifdef CSRARB_ROUNDROBIN_EN
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       gnt_en,
`endif
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_idx
);

`ifdef CSRARB_ROUNDROBIN_EN
  // Index of the requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic last_q, last_d;

  always_comb begin
    gnt_vld = req[0] | req[1];
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = req[1];
    end
    last_d = (gnt_en && gnt_vld) ? gnt_idx : last_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    gnt_vld = req[0] | req[1];
    gnt_idx = ~req[0];
  end
`endif

endmodule

// File: rtl/csrarb.sv
// Two-requester CSR bus arbiter: one shared IDLE/WAIT/ACK FSM drives a single CSR port.
// Latency: write ack 1 cycle after the request is sampled, read ack READ_WAIT+1 cycles.
// Backpressure: requesters hold mN_req until their one-cycle mN_ack; inputs ignored while busy.
//
// Ports: sys_clk/sys_rst (sync, active-high); per requester N: mN_req, mN_we, mN_adr,
// mN_dat_i in, mN_dat_o, mN_ack out; CSR side: csr_a, csr_we, csr_do out, csr_di in.
// Optional CSRARB_ROUNDROBIN_EN: alternate grants on ties (else requester 0 wins ties).
module csrarb
  import csrarb_pkg::*;
#(
  parameter int READ_WAIT = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack,
  output logic [ADR_W-1:0] csr_a,
  output logic             csr_we,
  output logic [DAT_W-1:0] csr_do,
  input  logic [DAT_W-1:0] csr_di
);

  localparam logic [2:0] RW_INIT = 3'(READ_WAIT);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             gnt_q, gnt_d;   // owner of the transaction in flight
  logic [ADR_W-1:0] csr_a_q, csr_a_d;
  logic [DAT_W-1:0] csr_do_q, csr_do_d;
  logic             csr_we_q, csr_we_d;
  logic             m0_ack_q, m0_ack_d;
  logic             m1_ack_q, m1_ack_d;
  logic [DAT_W-1:0] m0_dat_q, m0_dat_d;
  logic [DAT_W-1:0] m1_dat_q, m1_dat_d;

  logic             arb_vld;
  logic             arb_idx;
  logic             sel_we;
  logic [ADR_W-1:0] sel_adr;
  logic [DAT_W-1:0] sel_dat;

  csrarb_rr u_rr (
`ifdef CSRARB_ROUNDROBIN_EN
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .gnt_en  (state_q == IDLE),
`endif
    .req     ({m1_req, m0_req}),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    sel_we  = arb_idx ? m1_we    : m0_we;
    sel_adr = arb_idx ? m1_adr   : m0_adr;
    sel_dat = arb_idx ? m1_dat_i : m0_dat_i;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    csr_a_d  = csr_a_q;
    csr_do_d = csr_do_q;
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    // Strobes are single-cycle: they drop unless explicitly raised below.
    csr_we_d = 1'b0;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_idx;
          csr_a_d  = sel_adr;
          csr_do_d = sel_dat;
          if (sel_we) begin
            // Write completes in the same cycle the strobe reaches the CSR bus.
            state_d  = ACK;
            csr_we_d = 1'b1;
            m0_ack_d = ~arb_idx;
            m1_ack_d = arb_idx;
          end else begin
            state_d = WAIT;
            cnt_d   = RW_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ACK;
          cnt_d   = 3'd0;
          if (gnt_q) begin
            m1_ack_d = 1'b1;
            m1_dat_d = csr_di;
          end else begin
            m0_ack_d = 1'b1;
            m0_dat_d = csr_di;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      gnt_q    <= 1'b0;
      csr_a_q  <= '0;
      csr_do_q <= '0;
      csr_we_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_dat_q <= '0;
      m1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      csr_a_q  <= csr_a_d;
      csr_do_q <= csr_do_d;
      csr_we_q <= csr_we_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
    end
  end

  assign csr_a    = csr_a_q;
  assign csr_do   = csr_do_q;
  assign csr_we   = csr_we_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_dat_o = m0_dat_q;
  assign m1_dat_o = m1_dat_q;

endmodule

// File: tb/tb_csrarb.sv
// Bench for csrarb: directed scenarios plus randomized traffic checked against a
// transaction-level model (grant order, ack cycle, CSR bus values, read data).
module tb_csrarb;

  localparam int RW_MAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (READ_WAIT=2, registered slave) ----------------
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [13:0] m0_adr = 0, m1_adr = 0;
  logic [31:0] m0_dat_i = 0, m1_dat_i = 0;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_do;
  logic [31:0] csr_di;

  csrarb #(.READ_WAIT(RW_MAIN)) u_dut (
    .sys_clk(clk), .sys_rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack(m1_ack),
    .csr_a(csr_a), .csr_we(csr_we), .csr_do(csr_do), .csr_di(csr_di)
  );

  // Slave memory contents are a fixed function of the address; 0x0040 holds 0x12345678.
  function automatic logic [31:0] slave_fn(input logic [13:0] a);
    return 32'h12345678 ^ (({18'd0, a} - 32'h40) * 32'h9E3779B1);
  endfunction

  // Data appears one cycle after the address.
  always @(posedge clk) csr_di <= slave_fn(csr_a);

  // ---------------- latency DUTs (READ_WAIT=1 and 7, combinational slave) ----------------
  logic        z1 = 0;
  logic [13:0] z14 = 0;
  logic [31:0] z32 = 0;
  logic        l1_req = 0, l7_req = 0, lt_we = 0;
  logic [13:0] lt_adr = 0;
  logic [31:0] lt_dat = 0;
  logic [31:0] l1_dat_o, l1_m1_dat_o, l1_csr_do, l1_csr_di;
  logic [31:0] l7_dat_o, l7_m1_dat_o, l7_csr_do, l7_csr_di;
  logic        l1_ack, l1_m1_ack, l1_csr_we, l7_ack, l7_m1_ack, l7_csr_we;
  logic [13:0] l1_csr_a, l7_csr_a;

  assign l1_csr_di = slave_fn(l1_csr_a);
  assign l7_csr_di = slave_fn(l7_csr_a);

  csrarb #(.READ_WAIT(1)) u_rw1 (
    .sys_clk(clk), .sys_rst(rst),
    .m0_req(l1_req), .m0_we(lt_we), .m0_adr(lt_adr), .m0_dat_i(lt_dat),
    .m0_dat_o(l1_dat_o), .m0_ack(l1_ack),
    .m1_req(z1), .m1_we(z1), .m1_adr(z14), .m1_dat_i(z32),
    .m1_dat_o(l1_m1_dat_o), .m1_ack(l1_m1_ack),
    .csr_a(l1_csr_a), .csr_we(l1_csr_we), .csr_do(l1_csr_do), .csr_di(l1_csr_di)
  );

  csrarb #(.READ_WAIT(7)) u_rw7 (
    .sys_clk(clk), .sys_rst(rst),
    .m0_req(l7_req), .m0_we(lt_we), .m0_adr(lt_adr), .m0_dat_i(lt_dat),
    .m0_dat_o(l7_dat_o), .m0_ack(l7_ack),
    .m1_req(z1), .m1_we(z1), .m1_adr(z14), .m1_dat_i(z32),
    .m1_dat_o(l7_m1_dat_o), .m1_ack(l7_m1_ack),
    .csr_a(l7_csr_a), .csr_we(l7_csr_we), .csr_do(l7_csr_do), .csr_di(l7_csr_di)
  );

  // ---------------- monitor on the main DUT ----------------
  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] dat;
    logic [13:0] a;
    logic [31:0] dout;
    logic        we;
  } ack_ev_t;

  ack_ev_t ack_q[$];
  int      we_cnt = 0;

  always @(negedge clk) begin
    if (m0_ack) ack_q.push_back('{cyc, 0, m0_dat_o, csr_a, csr_do, csr_we});
    if (m1_ack) ack_q.push_back('{cyc, 1, m1_dat_o, csr_a, csr_do, csr_we});
    if (csr_we) we_cnt <= we_cnt + 1;
  end

  // ---------------- reference model state ----------------
  int          exp_last;     // requester granted most recently
  logic [31:0] exp_dato[2];  // last read data delivered to each requester

  function automatic int model_winner(input int mask);
    if (mask == 1) return 0;
    if (mask == 2) return 1;
`ifdef CSRARB_ROUNDROBIN_EN
    return (exp_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int lat(input logic we);
    return we ? 1 : RW_MAIN + 1;
  endfunction

  task automatic model_reset();
    exp_last    = 1;
    exp_dato[0] = '0;
    exp_dato[1] = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input int idx, input logic we, input logic [13:0] adr,
                           input logic [31:0] dat);
    if (idx == 0) begin
      m0_req = 1; m0_we = we; m0_adr = adr; m0_dat_i = dat;
    end else begin
      m1_req = 1; m1_we = we; m1_adr = adr; m1_dat_i = dat;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1; m0_req = 0; m1_req = 0; l1_req = 0; l7_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  // Wait until n more acks have been recorded since base; drop each requester on its ack
  // unless hold is set. ok=0 if the budget runs out.
  task automatic wait_acks(input int base, input int n, input int budget, input bit hold,
                           output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!hold) begin
        if (m0_ack) m0_req = 0;
        if (m1_ack) m1_req = 0;
      end
      if (ack_q.size() - base >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (csr_a !== 14'h0) $display("FAIL reset csr_a: got %h want 0", csr_a); else passed++;
    checks++; if (csr_do !== 32'h0) $display("FAIL reset csr_do: got %h want 0", csr_do); else passed++;
    checks++; if (csr_we !== 1'b0) $display("FAIL reset csr_we: got %b want 0", csr_we); else passed++;
    checks++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL reset acks: got %b want 00", {m0_ack, m1_ack}); else passed++;
    checks++; if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0)
      $display("FAIL reset dat_o: got %h/%h want 0/0", m0_dat_o, m1_dat_o); else passed++;
    rst = 0;
    model_reset();
  endtask

  task automatic test_write();
    int t0, base, w0; bit ok; ack_ev_t e;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 14'h0123, 32'hDEADBEEF);
    t0 = cyc; base = ack_q.size(); w0 = we_cnt;
    wait_acks(base, 1, 10, 0, ok);
    checks++; if (!ok) $display("FAIL write timeout: no m0_ack within 10 cycles"); else passed++;
    if (ok) begin
      e = ack_q[base];
      checks++; if (e.idx !== 0) $display("FAIL write idx: got %0d want 0", e.idx); else passed++;
      checks++; if (e.cyc - t0 !== 1) $display("FAIL write latency: got %0d want 1", e.cyc - t0); else passed++;
      checks++; if (e.a !== 14'h0123) $display("FAIL write csr_a: got %h want 0123", e.a); else passed++;
      checks++; if (e.dout !== 32'hDEADBEEF) $display("FAIL write csr_do: got %h want deadbeef", e.dout); else passed++;
      checks++; if (e.we !== 1'b1) $display("FAIL write csr_we at ack: got %b want 1", e.we); else passed++;
      exp_last = 0;
    end
    @(negedge clk);
    checks++; if (csr_we !== 1'b0) $display("FAIL write csr_we at +2: got %b want 0", csr_we); else passed++;
    checks++; if (we_cnt - w0 !== 1) $display("FAIL write strobe count: got %0d want 1", we_cnt - w0); else passed++;
  endtask

  task automatic test_read();
    int t0, base, w0; bit ok; ack_ev_t e;
    @(posedge clk); #1;
    drive_req(1, 1'b0, 14'h0040, $urandom);
    t0 = cyc; base = ack_q.size(); w0 = we_cnt;
    wait_acks(base, 1, 10, 0, ok);
    checks++; if (!ok) $display("FAIL read timeout: no m1_ack within 10 cycles"); else passed++;
    if (ok) begin
      e = ack_q[base];
      checks++; if (e.idx !== 1) $display("FAIL read idx: got %0d want 1", e.idx); else passed++;
      checks++; if (e.cyc - t0 !== 3) $display("FAIL read latency: got %0d want 3", e.cyc - t0); else passed++;
      checks++; if (e.dat !== 32'h12345678) $display("FAIL read data: got %h want 12345678", e.dat); else passed++;
      checks++; if (e.a !== 14'h0040) $display("FAIL read csr_a: got %h want 0040", e.a); else passed++;
      exp_last = 1;
      exp_dato[1] = 32'h12345678;
    end
    @(negedge clk);
    checks++; if (we_cnt !== w0) $display("FAIL read csr_we pulses: got %0d want 0", we_cnt - w0); else passed++;
    checks++; if (m0_dat_o !== exp_dato[0]) $display("FAIL read other dat_o: got %h want %h", m0_dat_o, exp_dato[0]); else passed++;
  endtask

  task automatic test_tie();
    int t0, base, w; bit ok; ack_ev_t e;
    int exp_idx[4];
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      w = model_winner(3);
      exp_idx[k] = w;
      exp_last = w;
    end
    @(posedge clk); #1;
    drive_req(0, 1'b1, 14'h0A00, 32'hA0A0A0A0);
    drive_req(1, 1'b1, 14'h0B11, 32'hB1B1B1B1);
    t0 = cyc; base = ack_q.size();
    wait_acks(base, 4, 40, 1, ok);
    m0_req = 0; m1_req = 0;
    checks++; if (!ok) $display("FAIL tie timeout: %0d acks seen, want 4", ack_q.size() - base); else passed++;
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        e = ack_q[base + k];
        checks++; if (e.idx !== exp_idx[k]) $display("FAIL tie grant %0d: got m%0d want m%0d", k, e.idx, exp_idx[k]); else passed++;
        checks++; if (e.cyc - t0 !== 1 + 2 * k) $display("FAIL tie cycle %0d: got %0d want %0d", k, e.cyc - t0, 1 + 2 * k); else passed++;
        checks++; if (e.a !== (exp_idx[k] == 0 ? 14'h0A00 : 14'h0B11))
          $display("FAIL tie csr_a %0d: got %h", k, e.a); else passed++;
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_latency();
    int t0, c1, c7, n1, n7; bit we_seen, m1_seen; logic [31:0] d1, d7;
    @(posedge clk); #1;
    lt_adr = 14'($urandom); lt_dat = $urandom; lt_we = 0;
    l1_req = 1; l7_req = 1;
    t0 = cyc; c1 = -1; c7 = -1; n1 = 0; n7 = 0; we_seen = 0; m1_seen = 0; d1 = 0; d7 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (l1_csr_we || l7_csr_we) we_seen = 1;
      if (l1_m1_ack || l7_m1_ack) m1_seen = 1;
      if (l1_ack) begin n1++; if (c1 < 0) begin c1 = cyc - t0; d1 = l1_dat_o; end l1_req = 0; end
      if (l7_ack) begin n7++; if (c7 < 0) begin c7 = cyc - t0; d7 = l7_dat_o; end l7_req = 0; end
    end
    checks++; if (c1 !== 2) $display("FAIL rw1 latency: got %0d want 2", c1); else passed++;
    checks++; if (c7 !== 8) $display("FAIL rw7 latency: got %0d want 8", c7); else passed++;
    checks++; if (d1 !== slave_fn(lt_adr)) $display("FAIL rw1 data: got %h want %h", d1, slave_fn(lt_adr)); else passed++;
    checks++; if (d7 !== slave_fn(lt_adr)) $display("FAIL rw7 data: got %h want %h", d7, slave_fn(lt_adr)); else passed++;
    checks++; if (n1 !== 1 || n7 !== 1) $display("FAIL latency ack count: got %0d/%0d want 1/1", n1, n7); else passed++;
    checks++; if (we_seen !== 1'b0) $display("FAIL latency csr_we: got 1 want 0"); else passed++;
    checks++; if (m1_seen !== 1'b0 || l1_m1_dat_o !== 32'h0 || l7_m1_dat_o !== 32'h0)
      $display("FAIL latency idle m1: ack %b dat %h/%h want 0", m1_seen, l1_m1_dat_o, l7_m1_dat_o); else passed++;
    checks++; if (l1_csr_a !== lt_adr || l7_csr_a !== lt_adr)
      $display("FAIL latency csr_a: got %h/%h want %h", l1_csr_a, l7_csr_a, lt_adr); else passed++;
    checks++; if (l1_csr_do !== lt_dat || l7_csr_do !== lt_dat)
      $display("FAIL latency csr_do: got %h/%h want %h", l1_csr_do, l7_csr_do, lt_dat); else passed++;
  endtask

  task automatic test_reset_mid();
    int t0, base; bit ok; ack_ev_t e; logic [13:0] a;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 14'h0111, 32'h0);
    base = ack_q.size();
    @(posedge clk); #1;            // arbiter now in WAIT for this read
    rst = 1; m0_req = 0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (csr_we !== 1'b0 || csr_a !== 14'h0 || csr_do !== 32'h0)
      $display("FAIL midreset csr: we %b a %h do %h want 0", csr_we, csr_a, csr_do); else passed++;
    checks++; if ({m0_ack, m1_ack} !== 2'b00 || m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0)
      $display("FAIL midreset requester outs: ack %b dat %h/%h want 0", {m0_ack, m1_ack}, m0_dat_o, m1_dat_o); else passed++;
    rst = 0;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (ack_q.size() !== base) $display("FAIL midreset aborted ack: got %0d acks want 0", ack_q.size() - base); else passed++;
    a = 14'($urandom);
    drive_req(1, 1'b0, a, 32'h0);
    t0 = cyc; base = ack_q.size();
    wait_acks(base, 1, 10, 0, ok);
    checks++; if (!ok) $display("FAIL midreset fresh timeout"); else passed++;
    if (ok) begin
      e = ack_q[base];
      checks++; if (e.idx !== 1 || e.cyc - t0 !== 3) $display("FAIL midreset fresh: got m%0d at %0d want m1 at 3", e.idx, e.cyc - t0); else passed++;
      checks++; if (e.dat !== slave_fn(a)) $display("FAIL midreset fresh data: got %h want %h", e.dat, slave_fn(a)); else passed++;
      exp_last = 1;
      exp_dato[1] = slave_fn(a);
    end
  endtask

  task automatic test_input_change();
    int t0, base, w0; bit ok; ack_ev_t e;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 14'h0AAA, 32'h11111111);
    t0 = cyc; base = ack_q.size(); w0 = we_cnt;
    @(posedge clk); #1;
    m0_adr = 14'h1555; m0_we = 1; m0_dat_i = 32'h22222222;
    @(negedge clk);
    checks++; if (csr_a !== 14'h0AAA) $display("FAIL inchg csr_a in WAIT: got %h want 0aaa", csr_a); else passed++;
    wait_acks(base, 1, 10, 0, ok);
    m0_we = 0;
    checks++; if (!ok) $display("FAIL inchg timeout"); else passed++;
    if (ok) begin
      e = ack_q[base];
      checks++; if (e.a !== 14'h0AAA || e.dout !== 32'h11111111)
        $display("FAIL inchg held bus: got %h/%h want 0aaa/11111111", e.a, e.dout); else passed++;
      checks++; if (e.dat !== slave_fn(14'h0AAA) || e.cyc - t0 !== 3)
        $display("FAIL inchg read: got %h at %0d want %h at 3", e.dat, e.cyc - t0, slave_fn(14'h0AAA)); else passed++;
      exp_last = 0;
      exp_dato[0] = slave_fn(14'h0AAA);
    end
    checks++; if (we_cnt !== w0) $display("FAIL inchg csr_we pulses: got %0d want 0", we_cnt - w0); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 40; r++) begin
      int mask, n, base, t0, w0, nwr, i;
      bit ok;
      int ord[2];
      int ecyc[2];
      logic we_r[2];
      logic [13:0] adr_r[2];
      logic [31:0] dat_r[2];
      ack_ev_t e;
      mask = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        we_r[k] = 1'($urandom_range(0, 1));
        adr_r[k] = 14'($urandom);
        dat_r[k] = $urandom;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      if (mask[0]) drive_req(0, we_r[0], adr_r[0], dat_r[0]);
      if (mask[1]) drive_req(1, we_r[1], adr_r[1], dat_r[1]);
      t0 = cyc; base = ack_q.size(); w0 = we_cnt;
      ord[0] = model_winner(mask);
      ord[1] = 1 - ord[0];
      n = (mask == 3) ? 2 : 1;
      ecyc[0] = t0 + lat(we_r[ord[0]]);
      ecyc[1] = ecyc[0] + 1 + lat(we_r[ord[1]]);
      nwr = 0;
      for (int k = 0; k < n; k++) if (we_r[ord[k]]) nwr++;
      wait_acks(base, n, 40, 0, ok);
      checks++; if (!ok) $display("FAIL b2b[%0d] timeout: %0d of %0d acks", r, ack_q.size() - base, n); else passed++;
      if (ok) begin
        for (int k = 0; k < n; k++) begin
          e = ack_q[base + k];
          i = ord[k];
          checks++; if (e.idx !== i || e.cyc !== ecyc[k])
            $display("FAIL b2b[%0d] grant %0d: got m%0d at %0d want m%0d at %0d", r, k, e.idx, e.cyc - t0, i, ecyc[k] - t0); else passed++;
          checks++; if (e.a !== adr_r[i] || e.dout !== dat_r[i] || e.we !== we_r[i])
            $display("FAIL b2b[%0d] bus %0d: got %h/%h/%b want %h/%h/%b", r, k, e.a, e.dout, e.we, adr_r[i], dat_r[i], we_r[i]); else passed++;
          exp_last = i;
          if (!we_r[i]) exp_dato[i] = slave_fn(adr_r[i]);
          checks++; if (e.dat !== exp_dato[i]) $display("FAIL b2b[%0d] dat_o %0d: got %h want %h", r, k, e.dat, exp_dato[i]); else passed++;
        end
      end
      checks++; if (m0_dat_o !== exp_dato[0] || m1_dat_o !== exp_dato[1])
        $display("FAIL b2b[%0d] held dat_o: got %h/%h want %h/%h", r, m0_dat_o, m1_dat_o, exp_dato[0], exp_dato[1]); else passed++;
      checks++; if (we_cnt - w0 !== nwr) $display("FAIL b2b[%0d] csr_we pulses: got %0d want %0d", r, we_cnt - w0, nwr); else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_latency();
    test_reset_mid();
    test_input_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
